// File: rtl/vermibus_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one Vermibus target among N
// requesters. Ownership is taken when a request is accepted and held until
// the target signals ready. On completion the next owner is chosen in the
// same cycle, so transfers from different requesters run back to back.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner; grant is zero, target-side outputs are zero
// ST_BUSY | requester `owner` drives the target until tgt_valid & tgt_ready
module vermibus_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N-1:0]          req_valid,
    input  logic [N*AW-1:0]       req_address,
    input  logic [N*(DW/8)-1:0]   req_wstrobe,
    input  logic [N*DW-1:0]       req_wdata,
    output logic [N-1:0]          req_ready,
    output logic [DW-1:0]         req_rdata,
    output logic                  tgt_valid,
    output logic [AW-1:0]         tgt_address,
    output logic [DW/8-1:0]       tgt_wstrobe,
    output logic [DW-1:0]         tgt_wdata,
    input  logic [DW-1:0]         tgt_rdata,
    input  logic                  tgt_ready,
    output logic [N-1:0]          grant
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(N);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  owner, owner_nxt;
    logic [IW-1:0]  last, last_nxt;
    logic [N-1:0]   grant_nxt;

    logic [N-1:0]   cand;
    logic [IW-1:0]  scan_base;
    int             scan_idx;
    logic           win_found;
    logic [IW-1:0]  win_idx;

    // Read data is a plain pass-through; req_ready qualifies it per requester.
    assign req_rdata = tgt_rdata;

    // Round-robin scan starting after the previous owner. While busy the
    // current owner is excluded because its valid still shows the finishing
    // transfer; a genuine re-request from it goes through IDLE.
    always_comb begin
        cand      = req_valid;
        scan_base = last;
        if (state == ST_BUSY) begin
            cand      = req_valid & ~grant;
            scan_base = owner;
        end
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = (int'(scan_base) + k) % N;
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
    end

    // Target-side mux on the registered owner, then next-state selection.
    always_comb begin
        tgt_valid   = 1'b0;
        tgt_address = '0;
        tgt_wstrobe = '0;
        tgt_wdata   = '0;
        req_ready   = '0;
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        grant_nxt   = grant;

        if (state == ST_BUSY) begin
            tgt_valid   = req_valid[owner];
            tgt_address = req_address[int'(owner)*AW +: AW];
            tgt_wstrobe = req_wstrobe[int'(owner)*SW +: SW];
            tgt_wdata   = req_wdata[int'(owner)*DW +: DW];
            if (req_valid[owner] && tgt_ready) begin
                req_ready[owner] = 1'b1;
                last_nxt         = owner;
                if (win_found) begin
                    owner_nxt = win_idx;
                    grant_nxt = ONE_HOT0 << win_idx;
                end else begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            end
        end else begin
            if (win_found) begin
                state_nxt = ST_BUSY;
                owner_nxt = win_idx;
                grant_nxt = ONE_HOT0 << win_idx;
            end
        end
    end

    // State register; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= IW'(N - 1);
            grant <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            grant <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Bench for vermibus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_vermibus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N*AW-1:0]     req_address = '0;
    logic [N*SW-1:0]     req_wstrobe = '0;
    logic [N*DW-1:0]     req_wdata = '0;
    logic [N-1:0]        req_ready;
    logic [DW-1:0]       req_rdata;
    logic                tgt_valid;
    logic [AW-1:0]       tgt_address;
    logic [SW-1:0]       tgt_wstrobe;
    logic [DW-1:0]       tgt_wdata;
    logic [DW-1:0]       tgt_rdata = '0;
    logic                tgt_ready = 1'b0;
    logic [N-1:0]        grant;

    vermibus_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_address (req_address),
        .req_wstrobe (req_wstrobe),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .tgt_valid   (tgt_valid),
        .tgt_address (tgt_address),
        .tgt_wstrobe (tgt_wstrobe),
        .tgt_wdata   (tgt_wdata),
        .tgt_rdata   (tgt_rdata),
        .tgt_ready   (tgt_ready),
        .grant       (grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference model: owner is -1 when nobody holds the bus.
    int m_owner = -1;
    int m_last  = N - 1;

    function automatic int rr_pick(logic [N-1:0] v, int from, int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (i != excl && v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner <= -1;
            m_last  <= N - 1;
        end else if (m_owner < 0) begin
            m_owner <= rr_pick(req_valid, m_last, -1);
        end else if (req_valid[m_owner] && tgt_ready) begin
            m_last  <= m_owner;
            m_owner <= rr_pick(req_valid, m_owner, m_owner);
        end
    end

    task automatic check_model(string tag);
        logic [N-1:0]  e_grant, e_ready;
        logic          e_tv;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_ws;
        logic [DW-1:0] e_wd;
        e_grant = '0;
        e_ready = '0;
        e_tv    = 1'b0;
        e_addr  = '0;
        e_ws    = '0;
        e_wd    = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_tv   = req_valid[m_owner];
            e_addr = req_address[m_owner*AW +: AW];
            e_ws   = req_wstrobe[m_owner*SW +: SW];
            e_wd   = req_wdata[m_owner*DW +: DW];
            if (e_tv && tgt_ready) e_ready[m_owner] = 1'b1;
        end
        chk($sformatf("%s grant", tag),       64'(grant),       64'(e_grant));
        chk($sformatf("%s tgt_valid", tag),   64'(tgt_valid),   64'(e_tv));
        chk($sformatf("%s tgt_address", tag), 64'(tgt_address), 64'(e_addr));
        chk($sformatf("%s tgt_wstrobe", tag), 64'(tgt_wstrobe), 64'(e_ws));
        chk($sformatf("%s tgt_wdata", tag),   64'(tgt_wdata),   64'(e_wd));
        chk($sformatf("%s req_ready", tag),   64'(req_ready),   64'(e_ready));
        chk($sformatf("%s req_rdata", tag),   64'(req_rdata),   64'(tgt_rdata));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  rv;
        logic          tr;
        logic [AW-1:0] a0;
        logic [N-1:0]  e_grant;
        logic          e_tv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [N-1:0]  e_ready;
    } vec_t;

    vec_t vt[$];

    function automatic void add(logic rst, logic [N-1:0] rv, logic tr, logic [AW-1:0] a0,
                                logic [N-1:0] eg, logic etv, logic [AW-1:0] ea,
                                logic [DW-1:0] ewd, logic [N-1:0] er);
        vec_t v;
        v.rst = rst; v.rv = rv; v.tr = tr; v.a0 = a0;
        v.e_grant = eg; v.e_tv = etv; v.e_addr = ea; v.e_wd = ewd; v.e_ready = er;
        vt.push_back(v);
    endfunction

    initial begin
        // single transfer from r0 with zero-wait target
        add(0, 2'b01, 1, 32'h0, 2'b00, 0, 32'h0,    32'h0,  2'b00);
        add(0, 2'b01, 1, 32'h0, 2'b01, 1, 32'h0,    32'h0,  2'b01);
        add(0, 2'b00, 0, 32'h0, 2'b00, 0, 32'h0,    32'h0,  2'b00);
        // both valid after reset: r0 then r1 with no bubble
        add(1, 2'b11, 1, 32'h4, 2'b00, 0, 32'h0,    32'h0,  2'b00);
        add(0, 2'b11, 1, 32'h4, 2'b01, 1, 32'h4,    32'h0,  2'b01);
        add(0, 2'b10, 1, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b10);
        add(0, 2'b00, 0, 32'h4, 2'b00, 0, 32'h0,    32'h0,  2'b00);
        // r1 owns, target stalls 3 cycles while r0 waits
        add(0, 2'b10, 0, 32'h4, 2'b00, 0, 32'h0,    32'h0,  2'b00);
        add(0, 2'b11, 0, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b00);
        add(0, 2'b11, 0, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b00);
        add(0, 2'b11, 0, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b00);
        add(0, 2'b11, 1, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b10);
        add(0, 2'b01, 0, 32'h4, 2'b01, 1, 32'h4,    32'h0,  2'b00);
        // both permanently valid: strict alternation
        add(0, 2'b11, 1, 32'h4, 2'b01, 1, 32'h4,    32'h0,  2'b01);
        add(0, 2'b11, 1, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b10);
        add(0, 2'b11, 1, 32'h4, 2'b01, 1, 32'h4,    32'h0,  2'b01);
        add(0, 2'b11, 1, 32'h4, 2'b10, 1, 32'hA100, 32'h96, 2'b10);
        // owner r0 drops valid before ready: grant held, no completion
        add(0, 2'b00, 0, 32'h4, 2'b01, 0, 32'h4,    32'h0,  2'b00);
        add(0, 2'b00, 1, 32'h4, 2'b01, 0, 32'h4,    32'h0,  2'b00);
        add(0, 2'b01, 1, 32'h4, 2'b01, 1, 32'h4,    32'h0,  2'b01);
        add(0, 2'b00, 0, 32'h4, 2'b00, 0, 32'h0,    32'h0,  2'b00);

        // reset state
        #3;
        chk("reset grant",     64'(grant),     64'(0));
        chk("reset tgt_valid", 64'(tgt_valid), 64'(0));
        chk("reset req_ready", 64'(req_ready), 64'(0));
        check_model("reset");
        next_cycle();
        reset_n = 1'b1;

        // directed table
        req_wstrobe = {4'hF, 4'h0};
        req_wdata   = {32'h96, 32'h0};
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) begin
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
            end
            req_valid   = vt[i].rv;
            tgt_ready   = vt[i].tr;
            req_address = {32'hA100, vt[i].a0};
            #1;
            chk($sformatf("row%0d grant", i),     64'(grant),       64'(vt[i].e_grant));
            chk($sformatf("row%0d tgt_valid", i), 64'(tgt_valid),   64'(vt[i].e_tv));
            chk($sformatf("row%0d tgt_addr", i),  64'(tgt_address), 64'(vt[i].e_addr));
            chk($sformatf("row%0d tgt_wdata", i), 64'(tgt_wdata),   64'(vt[i].e_wd));
            chk($sformatf("row%0d req_ready", i), 64'(req_ready),   64'(vt[i].e_ready));
            check_model($sformatf("row%0d", i));
            next_cycle();
        end

        // load: read data broadcast, ready pulse only to owner r0
        reset_n = 1'b0;
        #1;
        reset_n   = 1'b1;
        req_valid = 2'b11;
        tgt_ready = 1'b0;
        tgt_rdata = 32'h8C15F3E4;
        next_cycle();
        tgt_ready = 1'b1;
        #1;
        chk("load rdata", 64'(req_rdata), 64'(32'h8C15F3E4));
        chk("load ready", 64'(req_ready), 64'(2'b01));
        chk("load grant", 64'(grant),     64'(2'b01));
        check_model("load");
        next_cycle();

        // reset mid-transfer: everything drops at once, r0 wins after release
        reset_n = 1'b0;
        #1;
        reset_n   = 1'b1;
        req_valid = 2'b01;
        tgt_ready = 1'b0;
        next_cycle();
        req_valid = 2'b11;
        #1;
        chk("midrst busy tv", 64'(tgt_valid), 64'(1));
        tgt_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        chk("midrst tv",    64'(tgt_valid), 64'(0));
        chk("midrst grant", 64'(grant),     64'(0));
        chk("midrst ready", 64'(req_ready), 64'(0));
        check_model("midrst");
        next_cycle();
        reset_n   = 1'b1;
        tgt_ready = 1'b0;
        #1;
        chk("midrst idle grant", 64'(grant), 64'(0));
        next_cycle();
        chk("midrst first win", 64'(grant), 64'(2'b01));

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            req_valid   = N'($urandom);
            tgt_ready   = ($urandom_range(0, 2) != 0);
            req_address = {$urandom, $urandom};
            req_wstrobe = (N*SW)'($urandom);
            req_wdata   = {$urandom, $urandom};
            tgt_rdata   = $urandom;
            #1;
            check_model($sformatf("rand%0d", c));
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
